multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle main decoder. A Moore FSM sequences each MIPS instruction over 3-5 states: fetch, decode, execute/address, memory, writeback. Memory accesses wait on a ready handshake, with a bounded wait timeout. Sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath.

Parameters:
OPCODE_W, 6, opcode field width
ALU_OP_W, 3, ALU_Op width
MEM_TIMEOUT, 15, max consecutive not-ready cycles in a memory state before fault; 0 disables timeout
CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
Clk  in  1  clock; all state changes on rising edge
Reset_N  in  1  asynchronous, active-low reset
Opcode  in  OPCODE_W  IR[31:26]
Mem_Ready  in  1  memory completes current read/write this cycle
PC_Write  out  1  unconditional PC load
PC_Write_Cond_Ne  out  1  PC load if ALU Zero==0 (bne)
PC_Source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
IorD  out  1  0 PC address, 1 ALUOut address
Mem_Read  out  1  memory read request
Mem_Write  out  1  memory write request
IR_Write  out  1  load IR
Reg_Dst  out  2  00 rt, 01 rd, 10 $ra
Mem_to_Reg  out  2  00 ALUOut, 01 MDR, 10 PC
Reg_Write  out  1  register file write
ALU_Src_A  out  1  0 PC, 1 rs
ALU_Src_B  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
ALU_Op  out  ALU_OP_W  000 add, 001 sub, 010 R-funct, 011 and, 100 or, 101 slt, 110 xor, 111 lui
Fault  out  1  sticky fault flag
Fault_Code  out  2  00 none, 01 illegal opcode, 10 memory timeout
State  out  4  current state encoding (debug)

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, JUMP=11, JAL=12, FAULT=13.
- Reset (Reset_N low, asynchronous): state IDLE, wait counter 0, Fault=0, Fault_Code=00. Every output not listed in a state is 0; IDLE drives all outputs 0.
- IDLE -> FETCH unconditionally.
- FETCH: Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=000, PC_Source=00. IR_Write and PC_Write are asserted only in the cycle Mem_Ready=1; that cycle -> DECODE. Otherwise stay in FETCH.
- DECODE: ALU_Src_A=0, ALU_Src_B=11, ALU_Op=000. Next state by opcode:
  - 0 -> EXEC_R
  - 35, 43 -> MEM_ADDR
  - 8, 10, 12, 13, 14, 15 -> EXEC_I
  - 5 -> BRANCH
  - 2 -> JUMP
  - 3 -> JAL
  - any other -> FAULT, Fault_Code=01
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=000 -> MEM_RD for loads, MEM_WR for stores.
- MEM_RD: IorD=1, Mem_Read=1; on Mem_Ready -> MEM_WB.
- MEM_WB: Reg_Dst=00, Mem_to_Reg=01, Reg_Write=1 -> FETCH.
- MEM_WR: IorD=1, Mem_Write=1; on Mem_Ready -> FETCH.
- EXEC_R: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=010 -> ALU_WB.
- EXEC_I: ALU_Src_A=1, ALU_Src_B=10; ALU_Op from opcode: 8->000, 12->011, 13->100, 10->101, 14->110, 15->111. -> ALU_WB.
- ALU_WB: Reg_Write=1, Mem_to_Reg=00, Reg_Dst=01 if Opcode==0 else 00 -> FETCH.
- BRANCH: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=001, PC_Write_Cond_Ne=1, PC_Source=01 -> FETCH.
- JUMP: PC_Write=1, PC_Source=10 -> FETCH.
- JAL: PC_Write=1, PC_Source=10, Reg_Dst=10, Mem_to_Reg=10, Reg_Write=1 -> FETCH. The register file captures the pre-edge PC, i.e. PC+4.
- CPI: R/I-type 4, lw 5, sw 4, bne/j/jal 3 (each with zero memory wait).
- Wait counter: increments each cycle in FETCH/MEM_RD/MEM_WR while Mem_Ready=0; clears on Mem_Ready or on leaving the state. If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with Mem_Ready still 0 -> FAULT, Fault_Code=10. Mem_Ready arriving in the same cycle the limit is reached wins; no fault.
- FAULT: all control outputs 0, Fault=1. Exit only via reset.
- Reset asserted mid-instruction: immediate return to IDLE; no partial write strobes after assertion.
- Opcode is sampled combinationally in DECODE, EXEC_I and ALU_WB; IR must hold it stable until the next FETCH completes.

Optional Feature:
CTRL_SUBWORD_EN:
- Defined: opcodes 32/33 (lb/lh) are loads and 40/41 (sb/sh) are stores via MEM_ADDR. Adds output Mem_Size[1:0] (00 word, 01 half, 10 byte), valid in MEM_RD/MEM_WR, 00 elsewhere. Also adds output Load_Signed (1 for lb/lh in MEM_WB).
- Undefined: opcodes 32, 33, 40, 41 go to FAULT with code 01; the ports do not exist.

Test Plan:
- Reset low mid-MEM_RD, release -> State=0 immediately, then 1; all strobes 0 during reset, Fault=0.
- add (Opcode 0), Mem_Ready tied 1 -> State 1,2,7,9,1; Reg_Write=1 and Reg_Dst=01 only in ALU_WB; 4 cycles per instruction.
- lw (35), Mem_Ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; MEM_WB has Mem_to_Reg=01; no fault.
- jal (3) -> State 1,2,12; PC_Write=1, PC_Source=10, Reg_Dst=10, Mem_to_Reg=10, Reg_Write=1 in one cycle.
- Opcode 6'd63 -> FAULT after DECODE, Fault_Code=01, all strobes 0 until reset; with macro off, 6'd40 also faults.
- Mem_Ready stuck 0 in FETCH, MEM_TIMEOUT=15 -> Fault_Code=10 after 15 FETCH cycles; with MEM_TIMEOUT=0, no fault after 100 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style control FSM for a shared-memory multi-cycle
// MIPS datapath. Each instruction runs fetch, decode, execute/address, and
// then memory and/or writeback. Memory states wait on mem_ready, and a
// bounded wait counter raises a sticky timeout fault.
//
// Optional feature macro: CTRL_SUBWORD_EN. When defined, lb/lh/sb/sh are
// accepted and the mem_size and load_signed outputs are added.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   opcode            IR[31:26]; sampled in DECODE, MEM_ADDR, EXEC_I,
//                     ALU_WB and MEM_WB
//   mem_ready         memory completes the current access this cycle
//   pc_write, pc_write_cond_ne, pc_source       PC update control
//   iord, mem_read, mem_write, ir_write         memory/IR control
//   reg_dst, mem_to_reg, reg_write              register file control
//   alu_src_a, alu_src_b, alu_op                ALU control
//   mem_size, load_signed                       subword access (macro only)
//   fault, fault_code (registered)              sticky fault status
//   state (registered)                          current state encoding (debug)
// The control strobes are decoded from the registered state. ir_write and
// pc_write in FETCH also depend on mem_ready, so they can assert in the
// cycle the fetch completes.
module multicycle_control #(
   parameter int unsigned OPCODE_W    = 6,
   parameter int unsigned ALU_OP_W    = 3,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond_ne,
   output logic [1:0]          pc_source,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
`ifdef CTRL_SUBWORD_EN
   output logic [1:0]          mem_size,
   output logic                load_signed,
`endif
   output logic                fault,
   output logic [1:0]          fault_code,
   output logic [3:0]          state
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_ALU_WB   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_FAULT    = 4'd13
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(10);
   localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(12);
   localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
   localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(14);
   localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(15);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);
`ifdef CTRL_SUBWORD_EN
   localparam logic [OPCODE_W-1:0] OP_LB    = OPCODE_W'(32);
   localparam logic [OPCODE_W-1:0] OP_LH    = OPCODE_W'(33);
   localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'(40);
   localparam logic [OPCODE_W-1:0] OP_SH    = OPCODE_W'(41);
`endif

   localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_LUI   = ALU_OP_W'(7);

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;

   localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 fault_q;
   logic [1:0]           fault_code_q, fault_code_d;
   logic                 mem_timeout;
   logic                 is_rtype, is_load, is_store, is_imm, is_bne, is_j, is_jal;
   logic [ALU_OP_W-1:0]  imm_alu_op;

   // Wait limit reached with memory still busy; a ready in the same cycle wins.
   assign mem_timeout = TIMEOUT_EN && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

   // Opcode classification.
   always_comb begin
      is_rtype   = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_imm     = 1'b0;
      is_bne     = 1'b0;
      is_j       = 1'b0;
      is_jal     = 1'b0;
      imm_alu_op = ALU_ADD;
      case (opcode)
         OP_RTYPE: is_rtype = 1'b1;
         OP_LW:    is_load  = 1'b1;
         OP_SW:    is_store = 1'b1;
`ifdef CTRL_SUBWORD_EN
         OP_LB, OP_LH: is_load  = 1'b1;
         OP_SB, OP_SH: is_store = 1'b1;
`endif
         OP_ADDI:  is_imm = 1'b1;
         OP_SLTI:  begin is_imm = 1'b1; imm_alu_op = ALU_SLT; end
         OP_ANDI:  begin is_imm = 1'b1; imm_alu_op = ALU_AND; end
         OP_ORI:   begin is_imm = 1'b1; imm_alu_op = ALU_OR;  end
         OP_XORI:  begin is_imm = 1'b1; imm_alu_op = ALU_XOR; end
         OP_LUI:   begin is_imm = 1'b1; imm_alu_op = ALU_LUI; end
         OP_BNE:   is_bne = 1'b1;
         OP_J:     is_j   = 1'b1;
         OP_JAL:   is_jal = 1'b1;
         default:  ;
      endcase
   end

   // State, wait counter and sticky fault registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         fault_q      <= 1'b0;
         fault_code_q <= FC_NONE;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fault_q      <= (state_d == S_FAULT);
         fault_code_q <= fault_code_d;
      end
   end

   // Next state, wait counter and control strobes.
   always_comb begin
      state_d          = state_q;
      cnt_d            = '0;
      fault_code_d     = fault_code_q;
      pc_write         = 1'b0;
      pc_write_cond_ne = 1'b0;
      pc_source        = 2'b00;
      iord             = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_dst          = 2'b00;
      mem_to_reg       = 2'b00;
      reg_write        = 1'b0;
      alu_src_a        = 1'b0;
      alu_src_b        = 2'b00;
      alu_op           = ALU_ADD;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (mem_timeout) begin
               state_d      = S_FAULT;
               fault_code_d = FC_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            if (is_rtype)                state_d = S_EXEC_R;
            else if (is_load || is_store) state_d = S_MEM_ADDR;
            else if (is_imm)             state_d = S_EXEC_I;
            else if (is_bne)             state_d = S_BRANCH;
            else if (is_j)               state_d = S_JUMP;
            else if (is_jal)             state_d = S_JAL;
            else begin
               state_d      = S_FAULT;
               fault_code_d = FC_ILLEGAL;
            end
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = is_load ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD, S_MEM_WR: begin
            iord      = 1'b1;
            mem_read  = (state_q == S_MEM_RD);
            mem_write = (state_q == S_MEM_WR);
            if (mem_ready) begin
               state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
            end else if (mem_timeout) begin
               state_d      = S_FAULT;
               fault_code_d = FC_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_MEM_WB: begin
            mem_to_reg = 2'b01;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = imm_alu_op;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = is_rtype ? 2'b01 : 2'b00;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a        = 1'b1;
            alu_op           = ALU_SUB;
            pc_write_cond_ne = 1'b1;
            pc_source        = 2'b01;
            state_d          = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

`ifdef CTRL_SUBWORD_EN
   // Access size only during the memory access itself; sign extension on writeback.
   always_comb begin
      mem_size    = 2'b00;
      load_signed = 1'b0;
      if (state_q == S_MEM_RD || state_q == S_MEM_WR) begin
         if (opcode == OP_LB || opcode == OP_SB)      mem_size = 2'b10;
         else if (opcode == OP_LH || opcode == OP_SH) mem_size = 2'b01;
      end
      if (state_q == S_MEM_WB) load_signed = (opcode == OP_LB) || (opcode == OP_LH);
   end
`endif

   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus randomized instruction
// streams. The reference model expands each instruction into the expected
// sequence of phases (with memory waits) and checks every cycle. A second
// instance with the timeout disabled covers the no-timeout case.
`timescale 1ns/1ps
module tb_multicycle_control;

   localparam int unsigned TMO = 15;
   localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_RD = 4, MEM_WB = 5,
                  MEM_WR = 6, EXEC_R = 7, EXEC_I = 8, ALU_WB = 9, BRANCH = 10, JUMP = 11,
                  JAL = 12, FAULT = 13;

   typedef struct {
      int st;
      bit rdy;
   } step_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;

   logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_srca, a_fault;
   logic [1:0] a_pcs, a_rdst, a_m2r, a_srcb, a_fc;
   logic [2:0] a_aop;
   logic [3:0] a_state;
   logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_srca, b_fault;
   logic [1:0] b_pcs, b_rdst, b_m2r, b_srcb, b_fc;
   logic [2:0] b_aop;
   logic [3:0] b_state;
`ifdef CTRL_SUBWORD_EN
   logic [1:0] a_msize, b_msize;
   logic       a_lsigned, b_lsigned;
`endif

   logic [18:0] a_ctrl, b_ctrl;
   assign a_ctrl = {a_pcw, a_pcwc, a_pcs, a_iord, a_mrd, a_mwr, a_irw, a_rdst, a_m2r, a_rw, a_srca, a_srcb, a_aop};
   assign b_ctrl = {b_pcw, b_pcwc, b_pcs, b_iord, b_mrd, b_mwr, b_irw, b_rdst, b_m2r, b_rw, b_srca, b_srcb, b_aop};

   int total = 0;
   int bad   = 0;
   step_t q[$];

   multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(a_pcw), .pc_write_cond_ne(a_pcwc), .pc_source(a_pcs), .iord(a_iord),
      .mem_read(a_mrd), .mem_write(a_mwr), .ir_write(a_irw), .reg_dst(a_rdst),
      .mem_to_reg(a_m2r), .reg_write(a_rw), .alu_src_a(a_srca), .alu_src_b(a_srcb),
      .alu_op(a_aop),
`ifdef CTRL_SUBWORD_EN
      .mem_size(a_msize), .load_signed(a_lsigned),
`endif
      .fault(a_fault), .fault_code(a_fc), .state(a_state)
   );

   multicycle_control #(.MEM_TIMEOUT(0)) dut_nt (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(b_pcw), .pc_write_cond_ne(b_pcwc), .pc_source(b_pcs), .iord(b_iord),
      .mem_read(b_mrd), .mem_write(b_mwr), .ir_write(b_irw), .reg_dst(b_rdst),
      .mem_to_reg(b_m2r), .reg_write(b_rw), .alu_src_a(b_srca), .alu_src_b(b_srcb),
      .alu_op(b_aop),
`ifdef CTRL_SUBWORD_EN
      .mem_size(b_msize), .load_signed(b_lsigned),
`endif
      .fault(b_fault), .fault_code(b_fc), .state(b_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Instruction classes: 0 R, 1 load, 2 store, 3 imm, 4 bne, 5 j, 6 jal, 7 illegal.
   function automatic int kind(input int op);
      case (op)
         0: return 0;
         35: return 1;
         43: return 2;
`ifdef CTRL_SUBWORD_EN
         32, 33: return 1;
         40, 41: return 2;
`endif
         8, 10, 12, 13, 14, 15: return 3;
         5: return 4;
         2: return 5;
         3: return 6;
         default: return 7;
      endcase
   endfunction

   function automatic logic [2:0] imm_op(input int op);
      case (op)
         12: return 3'b011;
         13: return 3'b100;
         10: return 3'b101;
         14: return 3'b110;
         15: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   // Expected control strobes for a phase, packed like a_ctrl.
   function automatic logic [18:0] exp_ctrl(input int st, input int op, input bit rdy);
      logic pcw, pcwc, iord, mrd, mwr, irw, rw, srca;
      logic [1:0] pcs, rdst, m2r, srcb;
      logic [2:0] aop;
      {pcw, pcwc, iord, mrd, mwr, irw, rw, srca} = '0;
      {pcs, rdst, m2r, srcb} = '0;
      aop = 3'b000;
      case (st)
         FETCH:    begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
         DECODE:   srcb = 2'b11;
         MEM_ADDR: begin srca = 1; srcb = 2'b10; end
         MEM_RD:   begin iord = 1; mrd = 1; end
         MEM_WB:   begin m2r = 2'b01; rw = 1; end
         MEM_WR:   begin iord = 1; mwr = 1; end
         EXEC_R:   begin srca = 1; aop = 3'b010; end
         EXEC_I:   begin srca = 1; srcb = 2'b10; aop = imm_op(op); end
         ALU_WB:   begin rw = 1; rdst = (op == 0) ? 2'b01 : 2'b00; end
         BRANCH:   begin srca = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
         JUMP:     begin pcw = 1; pcs = 2'b10; end
         JAL:      begin pcw = 1; pcs = 2'b10; rdst = 2'b10; m2r = 2'b10; rw = 1; end
         default:  ;
      endcase
      return {pcw, pcwc, pcs, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop};
   endfunction

   function automatic bit rnd();
      return bit'($urandom_range(0, 1));
   endfunction

   // Memory phase with w not-ready cycles; beyond the limit the access faults.
   function automatic bit push_wait(input int st, input int w);
      step_t s;
      if (w > int'(TMO)) begin
         for (int i = 0; i <= int'(TMO); i++) begin s.st = st; s.rdy = 1'b0; q.push_back(s); end
         return 1'b1;
      end
      for (int i = 0; i < w; i++) begin s.st = st; s.rdy = 1'b0; q.push_back(s); end
      s.st = st; s.rdy = 1'b1; q.push_back(s);
      return 1'b0;
   endfunction

   function automatic void push(input int st);
      step_t s;
      s.st = st;
      s.rdy = rnd();
      q.push_back(s);
   endfunction

   task automatic cyc(input logic [5:0] op, input bit rdy);
      @(negedge clk);
      opcode    = op;
      mem_ready = rdy;
      #1;
   endtask

   // Asynchronous reset assertion, then release at the next falling edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_state", 32'(a_state), IDLE);
      check("rst_ctrl", 32'(a_ctrl), 0);
      check("rst_fault", {30'd0, a_fault, a_fc}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("idle_state", 32'(a_state), IDLE);
      check("idle_ctrl", 32'(a_ctrl), 0);
   endtask

   // Run one instruction from FETCH with the given fetch/memory wait counts.
   task automatic run_instr(input int op, input int fw, input int mw);
      bit flt;
      int code;
      int k;
      int msz;
      q.delete();
      code = 2;
      flt  = push_wait(FETCH, fw);
      if (!flt) begin
         push(DECODE);
         k = kind(op);
         case (k)
            0: begin push(EXEC_R); push(ALU_WB); end
            1: begin push(MEM_ADDR); flt = push_wait(MEM_RD, mw); if (!flt) push(MEM_WB); end
            2: begin push(MEM_ADDR); flt = push_wait(MEM_WR, mw); end
            3: begin push(EXEC_I); push(ALU_WB); end
            4: push(BRANCH);
            5: push(JUMP);
            6: push(JAL);
            default: begin flt = 1'b1; code = 1; end
         endcase
      end
      if (flt) for (int i = 0; i < 3; i++) push(FAULT);
      foreach (q[i]) begin
         cyc(6'(op), q[i].rdy);
         check($sformatf("state op%0d", op), 32'(a_state), 32'(q[i].st));
         check($sformatf("ctrl op%0d st%0d", op, q[i].st), 32'(a_ctrl), 32'(exp_ctrl(q[i].st, op, q[i].rdy)));
         check($sformatf("fault op%0d", op), 32'(a_fault), (q[i].st == FAULT) ? 1 : 0);
         check($sformatf("fcode op%0d", op), 32'(a_fc), (q[i].st == FAULT) ? code : 0);
`ifdef CTRL_SUBWORD_EN
         msz = 0;
         if (q[i].st == MEM_RD || q[i].st == MEM_WR)
            msz = (op == 32 || op == 40) ? 2 : (op == 33 || op == 41) ? 1 : 0;
         check("mem_size", 32'(a_msize), msz);
         check("load_signed", 32'(a_lsigned), (q[i].st == MEM_WB && (op == 32 || op == 33)) ? 1 : 0);
`else
         msz = 0;
`endif
      end
      if (flt) do_reset();
   endtask

   initial begin
      int ops[16];
      int op;
      int fw;
      int mw;
      ops = '{0, 35, 43, 8, 10, 12, 13, 14, 15, 5, 2, 3, 32, 33, 40, 41};
      repeat (2) @(negedge clk);
      do_reset();

      // Directed: add, lw with memory waits, jal, illegal opcodes, wait boundaries.
      run_instr(0, 0, 0);
      run_instr(0, 0, 0);
      run_instr(35, 0, 3);
      run_instr(43, 2, 1);
      run_instr(3, 0, 0);
      run_instr(5, 1, 0);
      run_instr(15, 0, 0);
      run_instr(63, 0, 0);
      run_instr(40, 0, 0);
      run_instr(35, 15, 15);
      run_instr(43, 0, 16);
      run_instr(35, 16, 0);

      // Reset asserted in the middle of a memory read.
      cyc(6'd35, 1'b1);
      check("mid_fetch", 32'(a_state), FETCH);
      cyc(6'd35, 1'b1);
      cyc(6'd35, 1'b1);
      cyc(6'd35, 1'b0);
      check("mid_memrd", 32'(a_state), MEM_RD);
      check("mid_memrd_ctrl", 32'(a_ctrl), 32'(exp_ctrl(MEM_RD, 35, 1'b0)));
      #2;
      do_reset();
      cyc(6'd35, 1'b0);
      check("post_rst_fetch", 32'(a_state), FETCH);
      cyc(6'd35, 1'b1);
      check("post_rst_fetch2", 32'(a_state), FETCH);
      do_reset();

      // Randomized instruction stream.
      for (int n = 0; n < 200; n++) begin
         op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 15)];
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 3));
         run_instr(op, fw, mw);
      end

      // Memory stuck busy in FETCH: timeout instance faults, disabled instance waits.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         cyc(6'd0, 1'b0);
         check("stuck_state", 32'(a_state), (i <= int'(TMO)) ? FETCH : FAULT);
         check("stuck_fault", {30'd0, a_fault, a_fc}, (i <= int'(TMO)) ? 0 : 6);
         check("stuck_ctrl", 32'(a_ctrl), (i <= int'(TMO)) ? 32'(exp_ctrl(FETCH, 0, 1'b0)) : 0);
         check("nt_state", 32'(b_state), FETCH);
         check("nt_fault", {30'd0, b_fault, b_fc}, 0);
         check("nt_ctrl", 32'(b_ctrl), 32'(exp_ctrl(FETCH, 0, 1'b0)));
      end
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
